// File: rtl/nco_ctrl_pkg.sv
// nco_ctrl_pkg: sweep-controller state encoding and default widths.
package nco_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;
    localparam int DEF_PI_W    = 8;
    localparam int DEF_DWELL_W = 16;
    localparam int DEF_PRE_W   = 8;
endpackage

// File: rtl/nco_prescaler.sv
// nco_prescaler: reloadable down-counter giving a registered rate strobe and a terminal-count flag.
module nco_prescaler
    import nco_ctrl_pkg::*;
#(
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [PRE_W-1:0] div,
    output logic             strobe,
    output logic             last
);
    logic [PRE_W-1:0] cnt;
    logic             reload;

    assign last   = cnt == '0;
    assign reload = load || (en && last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            strobe <= 1'b0;
        end else begin
            strobe <= reload;
            cnt    <= reload ? div : (en ? cnt - 1'b1 : cnt);
        end
    end
endmodule

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: stepped-frequency sweep sequencer driving the NCO pi and clock enable.
// Define NCO_SWEEP_TRIANGLE_EN to add cfg_triangle (up-then-down sweeps).
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int PI_W    = DEF_PI_W,
    parameter int DWELL_W = DEF_DWELL_W,
    parameter int PRE_W   = DEF_PRE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [PI_W-1:0]    cfg_start_pi,
    input  logic [PI_W-1:0]    cfg_stop_pi,
    input  logic [PI_W-1:0]    cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [PRE_W-1:0]   cfg_prescale,
    input  logic               cfg_repeat,
`ifdef NCO_SWEEP_TRIANGLE_EN
    input  logic               cfg_triangle,
`endif
    output logic [PI_W-1:0]    pi_out,
    output logic               nco_clk_en,
    output logic               busy,
    output logic               done,
    output logic               sweep_wrap
);
    state_t             state;
    logic [PI_W-1:0]    start_sh, stop_sh, step_sh, step_pi;
    logic [DWELL_W-1:0] dwell_m1, dcnt;
    logic [PRE_W-1:0]   pre_sh;
    logic [PI_W:0]      up_pi;
    logic               rep_sh, go, last, tick, dwell_end, step_ok, fin;

    assign go        = state == IDLE && start && !abort;
    assign tick      = state == RUN && !abort && last;
    assign dwell_end = tick && dcnt == dwell_m1;
    assign up_pi     = {1'b0, pi_out} + {1'b0, step_sh};
    assign fin       = dwell_end && !step_ok && !rep_sh;

`ifdef NCO_SWEEP_TRIANGLE_EN
    logic          dir, tri_sh, dn_ok, use_dn;
    logic [PI_W:0] dn_pi;

    // Borrow bit guards the descent against wrapping below zero.
    assign dn_pi   = {1'b0, pi_out} - {1'b0, step_sh};
    assign dn_ok   = !dn_pi[PI_W] && dn_pi[PI_W-1:0] >= start_sh;
    assign use_dn  = dir || (tri_sh && up_pi > {1'b0, stop_sh});
    assign step_pi = use_dn ? dn_pi[PI_W-1:0] : up_pi[PI_W-1:0];
    assign step_ok = use_dn ? dn_ok : up_pi <= {1'b0, stop_sh};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir    <= 1'b0;
            tri_sh <= 1'b0;
        end else if (go) begin
            dir    <= 1'b0;
            tri_sh <= cfg_triangle;
        end else if (dwell_end) begin
            dir    <= step_ok && use_dn;
        end
    end
`else
    assign step_pi = up_pi[PI_W-1:0];
    assign step_ok = up_pi <= {1'b0, stop_sh};
`endif

    nco_prescaler #(.PRE_W(PRE_W)) u_pre (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (go),
        .en     (state == RUN && !abort && !fin),
        .div    (go ? cfg_prescale : pre_sh),
        .strobe (nco_clk_en),
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pi_out     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sweep_wrap <= 1'b0;
            dcnt       <= '0;
            start_sh   <= '0;
            stop_sh    <= '0;
            step_sh    <= '0;
            dwell_m1   <= '0;
            pre_sh     <= '0;
            rep_sh     <= 1'b0;
        end else begin
            done       <= 1'b0;
            sweep_wrap <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    state    <= RUN;
                    busy     <= 1'b1;
                    pi_out   <= cfg_start_pi;
                    dcnt     <= '0;
                    start_sh <= cfg_start_pi;
                    stop_sh  <= cfg_stop_pi;
                    step_sh  <= cfg_step;
                    dwell_m1 <= cfg_dwell == '0 ? '0 : cfg_dwell - 1'b1;
                    pre_sh   <= cfg_prescale;
                    rep_sh   <= cfg_repeat;
                end
                RUN: if (abort) begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    pi_out <= '0;
                end else if (tick) begin
                    dcnt <= dwell_end ? '0 : dcnt + 1'b1;
                    if (dwell_end) begin
                        if (step_ok) begin
                            pi_out <= step_pi;
                        end else if (rep_sh) begin
                            pi_out     <= start_sh;
                            sweep_wrap <= 1'b1;
                        end else begin
                            state  <= FIN;
                            busy   <= 1'b0;
                            pi_out <= '0;
                            done   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl: random and directed sweeps checked every cycle against a sequence-list model.
module tb_nco_sweep_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, cfg_repeat = 1'b0;
    logic [7:0]  cfg_start_pi = '0, cfg_stop_pi = '0, cfg_step = '0, cfg_prescale = '0;
    logic [15:0] cfg_dwell = '0;
`ifdef NCO_SWEEP_TRIANGLE_EN
    logic        cfg_triangle = 1'b0;
`endif
    logic [7:0]  pi_out;
    logic        nco_clk_en, busy, done, sweep_wrap;

    int errors = 0, checks = 0;
    bit chk_en = 0;
    // Model: idle/run/fin, cycle count k since the sweep began, and the list of pi values of one pass.
    int m_st = 0, k = 0, h = 1, p1 = 1, len = 1;
    bit m_rep = 0, m_endless = 0;
    int seq[$];
    logic [11:0] ev, av;
    int lit1[8] = '{10, 10, 20, 20, 30, 30, 40, 40};

    always #5 clk = ~clk;

    nco_sweep_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .cfg_start_pi (cfg_start_pi),
        .cfg_stop_pi  (cfg_stop_pi),
        .cfg_step     (cfg_step),
        .cfg_dwell    (cfg_dwell),
        .cfg_prescale (cfg_prescale),
        .cfg_repeat   (cfg_repeat),
`ifdef NCO_SWEEP_TRIANGLE_EN
        .cfg_triangle (cfg_triangle),
`endif
        .pi_out       (pi_out),
        .nco_clk_en   (nco_clk_en),
        .busy         (busy),
        .done         (done),
        .sweep_wrap   (sweep_wrap)
    );

    function automatic void build(int s, int e, int st, bit tri_on);
        int v;
        seq.delete();
        seq.push_back(s);
        m_endless = (st == 0) && (s <= e || tri_on);
        v = s;
        if (!m_endless) begin
            while (v + st <= e) begin
                v += st;
                seq.push_back(v);
            end
            if (tri_on)
                while (v - st >= s) begin
                    v -= st;
                    seq.push_back(v);
                end
        end
        len = seq.size();
    endfunction

    always @(posedge clk) begin
        bit tri_on;
        tri_on = 0;
`ifdef NCO_SWEEP_TRIANGLE_EN
        tri_on = cfg_triangle;
`endif
        if (!rst_n) m_st = 0;
        else if (m_st == 0) begin
            if (start && !abort) begin
                p1 = int'(cfg_prescale) + 1;
                h = (cfg_dwell == 0 ? 1 : int'(cfg_dwell)) * p1;
                m_rep = cfg_repeat;
                build(int'(cfg_start_pi), int'(cfg_stop_pi), int'(cfg_step), tri_on);
                k = 0;
                m_st = 1;
            end
        end else if (m_st == 1) begin
            if (abort) m_st = 0;
            else begin
                k++;
                if (!m_rep && !m_endless && k == len * h) m_st = 2;
            end
        end else m_st = 0;
    end

    // Expected {pi_out, nco_clk_en, busy, done, sweep_wrap}.
    function automatic logic [11:0] expv();
        logic [7:0] p;
        if (m_st == 1) begin
            p = 8'(m_endless ? seq[0] : seq[(k / h) % len]);
            return {p, k % p1 == 0, 1'b1, 1'b0, m_rep && !m_endless && k > 0 && k % (len * h) == 0};
        end
        return m_st == 2 ? 12'h002 : 12'h000;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            ev = expv();
            av = {pi_out, nco_clk_en, busy, done, sweep_wrap};
            checks++;
            if (av !== ev) begin
                errors++;
                $display("FAIL cycle_check t=%0t {pi,en,busy,done,wrap} got %h expected %h", $time, av, ev);
            end
        end
    end

    task automatic pin(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic int m_pi();
        logic [11:0] v;
        v = expv();
        return int'(v[11:4]);
    endfunction

    function automatic int m_bit(int b);
        logic [11:0] v;
        v = expv();
        return int'(v[b]);
    endfunction

    task automatic set_cfg(int s, int e, int st, int d, int p, bit r);
        cfg_start_pi = 8'(s);
        cfg_stop_pi = 8'(e);
        cfg_step = 8'(st);
        cfg_dwell = 16'(d);
        cfg_prescale = 8'(p);
        cfg_repeat = r;
    endtask

    task automatic go();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1;
        pin("reset_outputs", int'({pi_out, nco_clk_en, busy, done, sweep_wrap}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        set_cfg(10, 40, 10, 2, 0, 0);
        go();
        for (int i = 0; i < 8; i++) begin
            pin("t1_pi", m_pi(), lit1[i]);
            @(negedge clk);
        end
        pin("t1_done", m_bit(1), 1);
        @(negedge clk);
        pin("t1_idle_pi", m_pi(), 0);

        set_cfg(10, 40, 10, 2, 3, 0);
        go();
        for (int i = 0; i < 32; i++) begin
            pin("t2_pi_en", m_pi() * 2 + m_bit(3), (10 + 10 * (i / 8)) * 2 + (i % 4 == 0 ? 1 : 0));
            @(negedge clk);
        end
        pin("t2_done", m_bit(1), 1);
        @(negedge clk);

        set_cfg(240, 250, 10, 1, 0, 1);
        go();
        for (int i = 0; i < 6; i++) begin
            pin("t3_pi_wrap", m_pi() * 2 + m_bit(0), (i % 2 == 0 ? 240 : 250) * 2 + (i > 0 && i % 2 == 0 ? 1 : 0));
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        pin("t3_abort_busy", m_bit(2), 0);

        set_cfg(10, 40, 10, 2, 0, 0);
        go();
        for (int c = 1; c <= 6; c++) begin
            if (c == 3) begin
                pin("t4_pi_n3", m_pi(), 20);
                start = 1'b1;
            end
            if (c == 4) start = 1'b0;
            if (c == 5) abort = 1'b1;
            if (c == 6) abort = 1'b0;
            if (c < 6) @(negedge clk);
        end
        pin("t4_abort_idle", m_pi() + m_bit(2), 0);
        repeat (4) begin
            pin("t4_no_done", m_bit(1), 0);
            @(negedge clk);
        end

        go();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pin("t5_reset_outputs", int'({pi_out, nco_clk_en, busy, done, sweep_wrap}), 0);
        set_cfg(50, 20, 10, 2, 0, 0);
        @(negedge clk);
        go();
        pin("t5_pi0", m_pi(), 50);
        @(negedge clk);
        pin("t5_pi1", m_pi(), 50);
        @(negedge clk);
        pin("t5_done", m_bit(1), 1);
        @(negedge clk);

`ifdef NCO_SWEEP_TRIANGLE_EN
        cfg_triangle = 1'b1;
        set_cfg(10, 30, 10, 1, 0, 0);
        go();
        foreach (lit1[i]) begin
            if (i < 5) begin
                pin("t6_tri_pi", m_pi(), (i < 3 ? 10 + 10 * i : 50 - 10 * i));
                @(negedge clk);
            end
        end
        pin("t6_done", m_bit(1), 1);
        @(negedge clk);
`endif

        for (int c = 0; c < 20000; c++) begin
            start = $urandom_range(0, 7) == 0;
            abort = $urandom_range(0, 299) == 0;
            rst_n = $urandom_range(0, 3999) != 0;
            if ($urandom_range(0, 3) == 0) begin
                cfg_start_pi = $urandom_range(0, 1) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 255));
                cfg_stop_pi = $urandom_range(0, 1) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 255));
                cfg_step = $urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
                cfg_dwell = 16'($urandom_range(0, 3));
                cfg_prescale = 8'($urandom_range(0, 3));
                cfg_repeat = 1'($urandom_range(0, 1));
`ifdef NCO_SWEEP_TRIANGLE_EN
                cfg_triangle = 1'($urandom_range(0, 1));
`endif
            end
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
Sequencer that drives the NCO's phase-increment (`pi`) and `clk_en` inputs to produce stepped frequency sweeps (chirps).
- Sits between the control/config logic and the NCO, in the `pll_clock` domain.
- Holds each `pi` value for a programmable dwell, then steps it from a start value to a stop value.
- Sweeps once or repeats; gates the NCO rate through a prescaler.

Parameters:
- `PI_W`, 8, width of the phase increment (matches the NCO `pi` input).
- `DWELL_W`, 16, width of the dwell counter (counts prescaled strobes).
- `PRE_W`, 8, width of the prescaler divisor.

Ports:
- `clk`  in  1  system clock (`pll_clock` domain).
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `abort`  in  1  stop immediately and return to IDLE; no `done` pulse.
- `cfg_start_pi`  in  PI_W  first phase increment.
- `cfg_stop_pi`  in  PI_W  last allowed phase increment.
- `cfg_step`  in  PI_W  increment added per dwell.
- `cfg_dwell`  in  DWELL_W  strobes per `pi` value; 0 is treated as 1.
- `cfg_prescale`  in  PRE_W  `nco_clk_en` period minus 1.
- `cfg_repeat`  in  1  restart the sweep at the end instead of finishing.
- `pi_out`  out  PI_W  phase increment to the NCO.
- `nco_clk_en`  out  1  NCO clock enable strobe.
- `busy`  out  1  high while RUN.
- `done`  out  1  one-cycle pulse at normal sweep completion.
- `sweep_wrap`  out  1  one-cycle pulse on each repeat restart.

Behaviour:
- Reset (`rst_n`=0 at a `clk` edge):
  - state=IDLE.
  - `pi_out`=0, `nco_clk_en`=0, `busy`=0, `done`=0, `sweep_wrap`=0.
  - Prescaler and dwell counters cleared.
  - Reset mid-sweep aborts with no `done` pulse.
- States: IDLE, RUN, FIN.
- IDLE:
  - `pi_out`=0, `nco_clk_en`=0.
  - `start`=1 & `abort`=0 at edge N: latch all `cfg_*` into shadow registers, go to RUN.
  - From cycle N+1: `busy`=1, `pi_out`=`cfg_start_pi`.
  - `start` & `abort` together in IDLE: `abort` wins, remain IDLE.
- RUN:
  - Prescaler: `nco_clk_en`=1 on the first RUN cycle and every (`cfg_prescale`+1) cycles after; `cfg_prescale`=0 gives a constant 1.
  - The dwell counter increments on each strobe.
  - On the strobe that completes the dwell, compute next = `pi` + step in PI_W+1 bits.
  - next ≤ stop: `pi_out` <= next on the following cycle; dwell and prescaler counters restart.
  - next > stop, `cfg_repeat`=1: `pi_out` <= start, `sweep_wrap` pulses for one cycle concurrent with the reload.
  - next > stop, `cfg_repeat`=0: go to FIN.
- FIN, exactly one cycle:
  - `done`=1, `busy`=0, `nco_clk_en`=0, `pi_out`=0.
  - Then IDLE.
- Boundary cases:
  - No 8-bit wrap of `pi` is ever allowed; the overflow compare uses the PI_W+1 carry.
  - start > stop: one dwell at start, then end or repeat.
  - `cfg_step`=0: constant tone until `abort`.
- `abort` in RUN: IDLE at the next cycle; outputs go to their IDLE values; `done` is not asserted.
- `start` while `busy`: ignored. Config input changes while `busy`: ignored (shadowed).

Optional Feature:
- Macro: `NCO_SWEEP_TRIANGLE_EN`.
- Defined:
  - Adds input `cfg_triangle` (1 bit), latched with the other config.
  - When set, hitting the stop condition reverses direction: `pi` descends by step (PI_W+1 borrow check) while ≥ start.
  - Falling below start counts as end of sweep (repeat or FIN as above).
  - The stop value is held one dwell, not two.
- Undefined: port absent, up-sweep only, no direction register.

Decomposition:
- Package `nco_ctrl_pkg`:
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, FIN=2'd2.
  - Default widths `PI_W`/`DWELL_W`/`PRE_W`.
- Sub-module `nco_prescaler`: PRE_W down-counter with load, enable and strobe output; reused by any future NCO-rate logic.

Test Plan:
- start=10, stop=40, step=10, dwell=2, prescale=0, repeat=0; `start` at edge N -> `pi_out` 10,10,20,20,30,30,40,40 on cycles N+1..N+8; `done`=1 on N+9 only; then `pi_out`=0.
- Same config with prescale=3 -> `nco_clk_en` high 1 cycle in 4; each `pi` held 8 cycles; `done` at N+33.
- start=240, stop=250, step=10, dwell=1, repeat=1 -> `pi_out` 240, 250, 240, ...; `sweep_wrap` pulses on each return to 240; `pi_out` never equals 4.
- `abort` at N+5 of the first test -> `busy`=0 and `pi_out`=0 at N+6; `done` never asserted; a `start` at N+3 in the same run has no effect.
- `rst_n`=0 mid-sweep for one edge -> all outputs 0 next cycle; a later `start` with start=50, stop=20 -> one dwell at 50, then `done`.
- With `NCO_SWEEP_TRIANGLE_EN`: `cfg_triangle`=1, start=10, stop=30, step=10, dwell=1 -> `pi_out` 10, 20, 30, 20, 10, then `done`.
